// File: rtl/aes_dec_key_sched.sv
// AES decryption round-key source: expands the key one word/cycle, then streams round keys Nr..0.
// rk_valid rises 41/47/53 cycles after en for 128/192/256; keys held while rk_ready is low, no bubbles.
module aes_dec_key_sched #(
    parameter int NUM_WORDS = 60
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [1:0]   mod,
    input  logic [255:0] key,
    output logic         busy,
    output logic         err,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_idx,
    output logic         rk_last
);
    localparam int AW = $clog2(NUM_WORDS);

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;

    function automatic logic [7:0] sub_byte(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sub_byte(x[31:24]), sub_byte(x[23:16]), sub_byte(x[15:8]), sub_byte(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd4;
            2'b01:   return 4'd6;
            default: return 4'd8;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd10;
            2'b01:   return 4'd12;
            default: return 4'd14;
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    mode_q, mode_d;
    logic [AW-1:0] i_q, i_d;
    logic [2:0]    kcnt_q, kcnt_d;
    logic [7:0]    rcon_q, rcon_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          rk_valid_q, rk_valid_d;
    logic          rk_last_q, rk_last_d;
    logic [127:0]  rk_data_q, rk_data_d;
    logic [3:0]    rk_idx_q, rk_idx_d;

    logic [31:0]   w_q [NUM_WORDS];

    logic [3:0]    nk, nr;
    logic [AW-1:0] last_i, rd_base;
    logic [31:0]   w_prev, w_far, t_word, new_word;
    logic [127:0]  rk_next;
    logic          load_key, wr_word;

    // Datapath for the word being generated and the next round key to present.
    always_comb begin
        nk       = nk_of(mode_q);
        nr       = nr_of(mode_q);
        last_i   = AW'({nr, 2'b11});
        w_prev   = w_q[i_q - AW'(1)];
        w_far    = w_q[i_q - AW'(nk)];
        if (kcnt_q == 3'd0) begin
            t_word = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon_q, 24'h0};
        end else if (nk == 4'd8 && kcnt_q == 3'd4) begin
            t_word = sub_word(w_prev);
        end else begin
            t_word = w_prev;
        end
        new_word = w_far ^ t_word;
        rd_base  = AW'({rk_idx_q - 4'd1, 2'b00});
        rk_next  = {w_q[rd_base], w_q[rd_base + AW'(1)],
                    w_q[rd_base + AW'(2)], w_q[rd_base + AW'(3)]};
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        i_d        = i_q;
        kcnt_d     = kcnt_q;
        rcon_d     = rcon_q;
        busy_d     = busy_q;
        err_d      = 1'b0;
        rk_valid_d = rk_valid_q;
        rk_last_d  = rk_last_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        load_key   = 1'b0;
        wr_word    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    if (mod == 2'b11) begin
                        err_d = 1'b1;
                    end else begin
                        load_key = 1'b1;
                        mode_d   = mod;
                        i_d      = AW'(nk_of(mod));
                        kcnt_d   = 3'd0;
                        rcon_d   = 8'h01;
                        busy_d   = 1'b1;
                        state_d  = EXPAND;
                    end
                end
            end
            EXPAND: begin
                wr_word = 1'b1;
                i_d     = i_q + AW'(1);
                kcnt_d  = (kcnt_q == 3'(nk - 4'd1)) ? 3'd0 : kcnt_q + 3'd1;
                if (kcnt_q == 3'd0) begin
                    rcon_d = xtime(rcon_q);
                end
                // Final word goes straight into the first key; it is not readable from the store yet.
                if (i_q == last_i) begin
                    state_d    = STREAM;
                    rk_valid_d = 1'b1;
                    rk_last_d  = 1'b0;
                    rk_idx_d   = nr;
                    rk_data_d  = {w_q[i_q - AW'(3)], w_q[i_q - AW'(2)], w_prev, new_word};
                end
            end
            STREAM: begin
                if (rk_ready) begin
                    if (rk_idx_q == 4'd0) begin
                        state_d    = IDLE;
                        rk_valid_d = 1'b0;
                        rk_last_d  = 1'b0;
                        busy_d     = 1'b0;
                    end else begin
                        rk_idx_d  = rk_idx_q - 4'd1;
                        rk_data_d = rk_next;
                        rk_last_d = (rk_idx_q == 4'd1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            i_q        <= '0;
            kcnt_q     <= 3'd0;
            rcon_q     <= 8'h01;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            rk_valid_q <= 1'b0;
            rk_last_q  <= 1'b0;
            rk_data_q  <= '0;
            rk_idx_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            i_q        <= i_d;
            kcnt_q     <= kcnt_d;
            rcon_q     <= rcon_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            rk_valid_q <= rk_valid_d;
            rk_last_q  <= rk_last_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
        end
    end

    // Word store has no reset; every word is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (load_key) begin
            for (int j = 0; j < 8; j++) begin
                w_q[j] <= key[255 - 32*j -: 32];
            end
        end else if (wr_word) begin
            w_q[i_q] <= new_word;
        end
    end

    assign busy     = busy_q;
    assign err      = err_q;
    assign rk_valid = rk_valid_q;
    assign rk_last  = rk_last_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Bench for aes_dec_key_sched: reference key schedule plus cycle-level protocol model, compared every cycle.
module tb_aes_dec_key_sched;
    localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         rk_ready = 1'b0;
    logic [1:0]   mod = 2'b00;
    logic [255:0] key = '0;
    logic         busy, err, rk_valid, rk_last;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk_tab [15];

    logic         m_busy = 1'b0, m_err = 1'b0, m_valid = 1'b0, m_last = 1'b0;
    logic [3:0]   m_idx = 4'd0, m_nr = 4'd0;
    logic [127:0] m_data = '0;
    int           m_wait = 0;

    always #5 clk = ~clk;

    aes_dec_key_sched #(.NUM_WORDS(60)) dut (
        .clk(clk), .reset(reset), .en(en), .mod(mod), .key(key),
        .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_data(rk_data), .rk_idx(rk_idx), .rk_last(rk_last)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gpow(input logic [7:0] a, input int e);
        logic [7:0] r = 8'h01;
        for (int n = 0; n < e; n++) r = gmul(r, a);
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] sub_w(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    function automatic int expand_cycles(input logic [1:0] m);
        int nk = 4 + 2 * int'(m);
        return 4 * (nk + 7) - nk;
    endfunction

    // Textbook key expansion; round key r is words 4r..4r+3.
    task automatic compute_schedule(input logic [1:0] m, input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        int nk, nr;
        nk = 4 + 2 * int'(m);
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) t = sub_w({t[23:0], t[31:24]}) ^ {gpow(8'h02, i / nk - 1), 24'h0};
            else if (nk == 8 && i % nk == 4) t = sub_w(t);
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_tab[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Protocol model: countdown to the first key, then one key per accepted handshake.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_err <= 1'b0; m_valid <= 1'b0; m_last <= 1'b0;
            m_idx <= 4'd0; m_data <= '0; m_wait <= 0;
        end else begin
            m_err <= 1'b0;
            if (!m_busy) begin
                if (en && mod == 2'b11) begin
                    m_err <= 1'b1;
                end else if (en) begin
                    m_busy <= 1'b1;
                    m_nr   <= 4'd10 + 4'd2 * {2'b00, mod};
                    m_wait <= expand_cycles(mod);
                end
            end else if (m_wait > 0) begin
                m_wait <= m_wait - 1;
                if (m_wait == 1) begin
                    m_valid <= 1'b1;
                    m_idx   <= m_nr;
                    m_data  <= rk_tab[m_nr];
                    m_last  <= 1'b0;
                end
            end else if (m_valid && rk_ready) begin
                if (m_idx == 4'd0) begin
                    m_valid <= 1'b0; m_last <= 1'b0; m_busy <= 1'b0;
                end else begin
                    m_idx  <= m_idx - 4'd1;
                    m_data <= rk_tab[m_idx - 4'd1];
                    m_last <= (m_idx == 4'd1);
                end
            end
        end
    end

    always @(negedge clk) begin
        n_tests++;
        if ({busy, err, rk_valid, rk_last, rk_idx, rk_data} !==
            {m_busy, m_err, m_valid, m_last, m_idx, m_data}) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t busy %b/%b err %b/%b vld %b/%b last %b/%b idx %0d/%0d data %h/%h",
                     $time, busy, m_busy, err, m_err, rk_valid, m_valid, rk_last, m_last,
                     rk_idx, m_idx, rk_data, m_data);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, 128'(busy), 128'(0));
        chk({name, "_err"}, 128'(err), 128'(0));
        chk({name, "_valid"}, 128'(rk_valid), 128'(0));
        chk({name, "_last"}, 128'(rk_last), 128'(0));
        chk({name, "_idx"}, 128'(rk_idx), 128'(0));
        chk({name, "_data"}, rk_data, 128'(0));
    endtask

    task automatic start(input logic [1:0] m, input logic [255:0] k);
        mod = m; key = k; en = 1'b1;
    endtask

    task automatic wait_valid(input int lat, input bit pulse, input logic [255:0] k);
        int cyc = 0;
        while (!rk_valid && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
            en  = pulse && (cyc == 10);
            mod = 2'b11;
            key = ~k;
        end
        en = 1'b0;
        if (!rk_valid) begin
            n_tests++; n_fail++;
            $display("FAIL valid_timeout: rk_valid still 0 after %0d cycles", cyc);
        end
        chk("latency", 128'(cyc), 128'(lat));
    endtask

    task automatic stream(input int pat, input int nr, input logic [127:0] last_k);
        int xfers = 0, exp_idx = nr, guard = 0, ph = 0;
        bit done = 0;
        logic [127:0] pd;
        logic [3:0] pi;
        logic pr, pv, pl;
        while (!done && guard < 200) begin
            rk_ready = (pat == 0) ? 1'b1 : (ph % 3 == 0);
            ph++;
            pd = rk_data; pi = rk_idx; pr = rk_ready; pv = rk_valid; pl = rk_last;
            @(posedge clk); #2;
            guard++;
            if (pv && pr) begin
                chk("xfer_idx", 128'(pi), 128'(exp_idx));
                xfers++;
                exp_idx--;
                if (pl) begin
                    done = 1;
                    chk("last_key", pd, last_k);
                    chk("busy_after_last", 128'(busy), 128'(0));
                    chk("valid_after_last", 128'(rk_valid), 128'(0));
                end
            end else if (pv) begin
                chk("hold_data", rk_data, pd);
                chk("hold_idx", 128'(rk_idx), 128'(pi));
            end
        end
        rk_ready = 1'b0;
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL stream_timeout: last key not transferred after %0d cycles", guard);
        end
        chk("xfer_count", 128'(xfers), 128'(nr + 1));
    endtask

    task automatic run_full(input logic [1:0] m, input logic [255:0] k, input int pat, input int lat,
                            input int nr, input logic [127:0] first, input bit pulse);
        compute_schedule(m, k);
        chk("model_first", rk_tab[nr], first);
        chk("model_round0", rk_tab[0], K0);
        start(m, k);
        wait_valid(lat, pulse, k);
        chk("first_key", rk_data, first);
        chk("first_idx", 128'(rk_idx), 128'(nr));
        chk("first_last", 128'(rk_last), 128'(0));
        stream(pat, nr, K0);
    endtask

    initial begin
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = (x == 0) ? 8'h00 : gpow(8'(x), 254);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
        chk("sbox_00", 128'(sbox[0]), 128'(8'h63));
        chk("sbox_53", 128'(sbox[8'h53]), 128'(8'hed));

        repeat (3) @(posedge clk);
        #2;
        chk_zero("reset");
        reset = 1'b1;
        @(posedge clk); #2;

        run_full(2'b00, K128, 0, 41, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 0);
        run_full(2'b01, K192, 0, 47, 12, 128'ha4970a331a78dc09c418c271e3a41d5d, 0);
        run_full(2'b10, K256, 0, 53, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 0);
        run_full(2'b00, K128, 1, 41, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 1);

        mod = 2'b11; en = 1'b1;
        @(posedge clk); #2;
        en = 1'b0;
        chk("illegal_err", 128'(err), 128'(1));
        chk("illegal_busy", 128'(busy), 128'(0));
        chk("illegal_valid", 128'(rk_valid), 128'(0));
        @(posedge clk); #2;
        chk("illegal_err_pulse", 128'(err), 128'(0));

        compute_schedule(2'b00, K128);
        start(2'b00, K128);
        repeat (20) begin
            @(posedge clk); #2;
            en = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk_zero("abort_expand");
        @(posedge clk); #2;
        reset = 1'b1;

        start(2'b00, K128);
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #2;
            en = 1'b0;
            rk_ready = 1'b1;
            if (rk_valid && rk_idx == 4'd5) break;
        end
        chk("reached_idx5", 128'(rk_idx), 128'(5));
        reset = 1'b0;
        rk_ready = 1'b0;
        #1;
        chk_zero("abort_stream");
        @(posedge clk); #2;
        reset = 1'b1;

        run_full(2'b00, K128, 0, 41, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, 0);

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
